// File: rtl/sobel_window_ctrl_pkg.sv
// sobel_window_ctrl_pkg: shared pixel width, frame defaults, FSM encodings and clamp helper
package sobel_window_ctrl_pkg;
  localparam int PIX_W = 8;
  localparam int DEF_IMG_W = 320;
  localparam int DEF_IMG_H = 240;
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN = 1'b1;
  function automatic logic [PIX_W-1:0] sat_pix(input logic [11:0] m);
    return (m > 12'd255) ? 8'hFF : m[7:0];
  endfunction
endpackage

// File: rtl/sobel.sv
// sobel: combinational 3x3 Sobel kernel, |Gx|+|Gy| saturated to 255
module sobel import sobel_window_ctrl_pkg::*; (
  input  logic [PIX_W-1:0] i_p00, i_p01, i_p02,
  input  logic [PIX_W-1:0] i_p10, i_p11, i_p12,
  input  logic [PIX_W-1:0] i_p20, i_p21, i_p22,
  output logic [PIX_W-1:0] o_mag
);
  logic signed [11:0] w_gx, w_gy;
  logic [11:0] w_ax, w_ay;
  logic [PIX_W-1:0] w_unused_centre;
  function automatic logic signed [11:0] ext(input logic [PIX_W-1:0] p);
    return $signed({4'b0, p});
  endfunction
  always_comb begin
    w_gx = (ext(i_p02) + (ext(i_p12) <<< 1) + ext(i_p22)) - (ext(i_p00) + (ext(i_p10) <<< 1) + ext(i_p20));
    w_gy = (ext(i_p20) + (ext(i_p21) <<< 1) + ext(i_p22)) - (ext(i_p00) + (ext(i_p01) <<< 1) + ext(i_p02));
    w_ax = w_gx[11] ? -w_gx : w_gx;
    w_ay = w_gy[11] ? -w_gy : w_gy;
    o_mag = sat_pix(w_ax + w_ay);
    w_unused_centre = i_p11;
  end
endmodule

// File: rtl/sobel_line_buf.sv
// sobel_line_buf: one image line of pixels, asynchronous read, synchronous write, no reset
module sobel_line_buf import sobel_window_ctrl_pkg::*; #(
  parameter int DEPTH = DEF_IMG_W,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_addr,
  input  logic [PIX_W-1:0] i_wdata,
  output logic [PIX_W-1:0] o_rdata
);
  logic [PIX_W-1:0] r_mem [DEPTH];
  always_ff @(posedge clk)
    if (i_we) r_mem[i_addr] <= i_wdata;
  assign o_rdata = r_mem[i_addr];
endmodule

// File: rtl/sobel_window_ctrl.sv
// sobel_window_ctrl: buffers two lines of a raster stream, builds 3x3 windows and
// streams the registered Sobel magnitude of every interior pixel
module sobel_window_ctrl import sobel_window_ctrl_pkg::*; #(
  parameter int IMG_W = DEF_IMG_W,
  parameter int IMG_H = DEF_IMG_H
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PIX_W-1:0] in_pixel,
  input  logic             in_sof,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PIX_W-1:0] out_pixel,
  output logic             out_sof,
  output logic             out_eol,
  output logic             frame_done,
  output logic             sync_err
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] C_LAST = CW'(IMG_W - 1);
  localparam logic [CW-1:0] C_TWO = CW'(2);
  localparam logic [RW-1:0] R_LAST = RW'(IMG_H - 1);
  localparam logic [RW-1:0] R_TWO = RW'(2);
  logic [0:0] r_state;
  logic [CW-1:0] r_col, w_col;
  logic [RW-1:0] r_row, w_row;
  logic [PIX_W-1:0] r_wt0, r_wt1, r_wm0, r_wm1, r_wb0, r_wb1;
  logic [PIX_W-1:0] r_out_pixel, w_top, w_mid, w_mag;
  logic r_out_valid, r_out_sof, r_out_eol, r_frame_done, r_sync_err;
  logic w_accept, w_active, w_last, w_emit;
  assign in_ready = !r_out_valid || out_ready;
  assign out_valid = r_out_valid;
  assign out_pixel = r_out_pixel;
  assign out_sof = r_out_sof;
  assign out_eol = r_out_eol;
  assign frame_done = r_frame_done;
  assign sync_err = r_sync_err;
  // A start-of-frame pixel is always position (0,0), whatever the counters say
  always_comb begin
    w_accept = in_valid && in_ready;
    w_active = w_accept && (r_state == ST_RUN || in_sof);
    w_col = in_sof ? '0 : r_col;
    w_row = in_sof ? '0 : r_row;
    w_last = w_col == C_LAST && w_row == R_LAST;
    w_emit = w_active && w_col >= C_TWO && w_row >= R_TWO;
  end
  sobel_line_buf #(.DEPTH(IMG_W), .AW(CW)) u_lb0 (
    .clk(clk), .i_we(w_active), .i_addr(w_col), .i_wdata(in_pixel), .o_rdata(w_mid)
  );
  sobel_line_buf #(.DEPTH(IMG_W), .AW(CW)) u_lb1 (
    .clk(clk), .i_we(w_active), .i_addr(w_col), .i_wdata(w_mid), .o_rdata(w_top)
  );
  sobel u_sobel (
    .i_p00(r_wt0), .i_p01(r_wt1), .i_p02(w_top),
    .i_p10(r_wm0), .i_p11(r_wm1), .i_p12(w_mid),
    .i_p20(r_wb0), .i_p21(r_wb1), .i_p22(in_pixel),
    .o_mag(w_mag)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_col <= '0;
      r_row <= '0;
      {r_wt0, r_wt1, r_wm0, r_wm1, r_wb0, r_wb1} <= '0;
      r_out_valid <= 1'b0;
      r_out_pixel <= '0;
      r_out_sof <= 1'b0;
      r_out_eol <= 1'b0;
      r_frame_done <= 1'b0;
      r_sync_err <= 1'b0;
    end else begin
      if (w_active) begin
        {r_wt0, r_wt1} <= {r_wt1, w_top};
        {r_wm0, r_wm1} <= {r_wm1, w_mid};
        {r_wb0, r_wb1} <= {r_wb1, in_pixel};
        r_state <= w_last ? ST_IDLE : ST_RUN;
        r_col <= (w_col == C_LAST) ? '0 : w_col + 1'b1;
        r_row <= (w_col != C_LAST) ? w_row : (w_row == R_LAST) ? '0 : w_row + 1'b1;
      end
      r_frame_done <= w_active && w_last;
      r_sync_err <= w_accept && r_state == ST_RUN && in_sof && (r_col != '0 || r_row != '0);
      if (w_emit) begin
        r_out_valid <= 1'b1;
        r_out_pixel <= w_mag;
        r_out_sof <= w_col == C_TWO && w_row == R_TWO;
        r_out_eol <= w_col == C_LAST;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_sobel_window_ctrl.sv
// tb_sobel_window_ctrl: table-driven frames, hand-written corner sequences and random
// frames checked against a whole-image reference model
module tb_sobel_window_ctrl;
  localparam int W = 5;
  localparam int H = 4;
  typedef struct {
    logic [7:0] lv;
    logic [7:0] rv;
    int split;
    logic [7:0] e0, e1, e2;
  } vec_t;
  typedef struct {
    logic [7:0] pix;
    logic sof;
    logic eol;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic in_valid = 1'b0;
  logic [7:0] in_pixel = '0;
  logic in_sof = 1'b0;
  logic out_ready = 1'b1;
  logic in_ready, out_valid, out_sof, out_eol, frame_done, sync_err;
  logic [7:0] out_pixel;
  int total = 0;
  int bad = 0;
  vec_t tbl[4];
  exp_t exp_q[$];
  logic [7:0] img [H][W];
  int mdl_pos = 0;
  bit mdl_run = 0;
  bit fd_next = 0, fd_now = 0, se_next = 0, se_now = 0;
  int fd_cnt = 0, se_cnt = 0;
  bit rnd_mode = 0, hold_low = 0;
  bit prev_stall = 0;
  logic [7:0] prev_pix;
  logic prev_sof, prev_eol;
  logic [7:0] cap_pix [64];
  logic cap_sof [64];
  logic cap_eol [64];
  int cap_n = 0;
  sobel_window_ctrl #(.IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_pixel(in_pixel), .in_sof(in_sof), .out_valid(out_valid), .out_ready(out_ready),
    .out_pixel(out_pixel), .out_sof(out_sof), .out_eol(out_eol),
    .frame_done(frame_done), .sync_err(sync_err)
  );
  initial forever #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask
  task automatic tick;
    @(negedge clk);
    #1;
  endtask
  function automatic logic [7:0] ref_sobel(int r, int c);
    int gx = 0, gy = 0, m;
    for (int dr = -1; dr <= 1; dr++)
      for (int dc = -1; dc <= 1; dc++) begin
        gx += dc * (dr == 0 ? 2 : 1) * int'(img[r+dr][c+dc]);
        gy += dr * (dc == 0 ? 2 : 1) * int'(img[r+dr][c+dc]);
      end
    m = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    return (m > 255) ? 8'd255 : 8'(m);
  endfunction
  task automatic model_accept(input logic [7:0] p, input logic s);
    int r, c;
    exp_t e;
    if (!mdl_run && !s) return;
    if (s) begin
      if (mdl_run && mdl_pos != 0) se_next = 1;
      mdl_pos = 0;
      mdl_run = 1;
    end
    r = mdl_pos / W;
    c = mdl_pos % W;
    img[r][c] = p;
    if (r >= 2 && c >= 2) begin
      e.pix = ref_sobel(r - 1, c - 1);
      e.sof = (r == 2 && c == 2);
      e.eol = (c == W - 1);
      exp_q.push_back(e);
    end
    mdl_pos++;
    if (mdl_pos == W * H) begin
      mdl_pos = 0;
      mdl_run = 0;
      fd_next = 1;
    end
  endtask
  task automatic model_reset;
    exp_q.delete();
    mdl_pos = 0;
    mdl_run = 0;
    fd_next = 0;
    fd_now = 0;
    se_next = 0;
    se_now = 0;
    prev_stall = 0;
  endtask
  task automatic send(input logic [7:0] p, input logic s);
    int n = 0;
    in_valid = 1'b1;
    in_pixel = p;
    in_sof = s;
    while (!in_ready && n < 200) begin
      tick;
      n++;
    end
    if (n >= 200) chk("in_ready_timeout", n, 0);
    else model_accept(p, s);
    tick;
    in_valid = 1'b0;
    in_sof = 1'b0;
  endtask
  task automatic send_part(input int idx, input int cnt);
    for (int i = 0; i < cnt; i++)
      send((i % W) < tbl[idx].split ? tbl[idx].lv : tbl[idx].rv, i == 0);
  endtask
  task automatic drain;
    int n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 100) begin
      tick;
      n++;
    end
    chk("drain_timeout", n < 100, 1);
  endtask
  task automatic check_frame(input int idx);
    logic [7:0] e;
    chk("out_count", cap_n, 6);
    for (int i = 0; i < 6 && i < cap_n; i++) begin
      e = (i % 3 == 0) ? tbl[idx].e0 : (i % 3 == 1) ? tbl[idx].e1 : tbl[idx].e2;
      chk("tbl_pixel", cap_pix[i], e);
      chk("tbl_sof", cap_sof[i], i == 0);
      chk("tbl_eol", cap_eol[i], i % 3 == 2);
    end
  endtask
  initial forever begin
    @(negedge clk);
    out_ready = rnd_mode ? ($urandom_range(0, 3) != 0) : !hold_low;
  end
  initial forever begin
    exp_t e;
    @(negedge clk);
    #2;
    chk("in_ready_rule", in_ready, !out_valid || out_ready);
    if (prev_stall) begin
      chk("hold_valid", out_valid, 1);
      chk("hold_pixel", out_pixel, prev_pix);
      chk("hold_sof", out_sof, prev_sof);
      chk("hold_eol", out_eol, prev_eol);
    end
    prev_stall = out_valid && !out_ready;
    prev_pix = out_pixel;
    prev_sof = out_sof;
    prev_eol = out_eol;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("spurious_output", out_pixel, 32'hFFFF_FFFF);
      else begin
        e = exp_q.pop_front();
        chk("out_pixel", out_pixel, e.pix);
        chk("out_sof", out_sof, e.sof);
        chk("out_eol", out_eol, e.eol);
      end
      if (cap_n < 64) begin
        cap_pix[cap_n] = out_pixel;
        cap_sof[cap_n] = out_sof;
        cap_eol[cap_n] = out_eol;
        cap_n++;
      end
    end
    if (frame_done || fd_now) chk("frame_done", frame_done, fd_now);
    if (sync_err || se_now) chk("sync_err", sync_err, se_now);
    fd_cnt += int'(frame_done);
    se_cnt += int'(sync_err);
    fd_now = fd_next;
    fd_next = 0;
    se_now = se_next;
    se_next = 0;
  end
  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
  initial begin
    tbl[0] = '{8'd100, 8'd100, 0, 8'd0, 8'd0, 8'd0};
    tbl[1] = '{8'd0, 8'd200, 2, 8'd255, 8'd255, 8'd0};
    tbl[2] = '{8'd10, 8'd50, 3, 8'd0, 8'd160, 8'd160};
    tbl[3] = '{8'd200, 8'd190, 1, 8'd40, 8'd0, 8'd0};
    #2 rst_n = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_pixel", out_pixel, 0);
    chk("rst_out_sof", out_sof, 0);
    chk("rst_out_eol", out_eol, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_sync_err", sync_err, 0);
    tick;
    tick;
    rst_n = 1'b1;
    tick;
    for (int i = 0; i < 4; i++) begin
      cap_n = 0;
      send_part(i, W * H);
      drain;
      check_frame(i);
    end
    // backpressure: three cycles of out_ready low while an output is pending
    cap_n = 0;
    fork
      send_part(0, W * H);
      begin
        int n = 0;
        while (!out_valid && n < 100) begin
          tick;
          n++;
        end
        chk("bp_wait_valid", out_valid, 1);
        hold_low = 1;
        repeat (3) begin
          tick;
          chk("bp_in_ready", in_ready, 0);
        end
        hold_low = 0;
      end
    join
    drain;
    check_frame(0);
    // stray pixels before start of frame are dropped
    cap_n = 0;
    repeat (7) send(8'($urandom), 1'b0);
    drain;
    chk("discard_none", cap_n, 0);
    send_part(0, W * H);
    drain;
    check_frame(0);
    // restart mid-frame at (2,1)
    cap_n = 0;
    fd_cnt = 0;
    se_cnt = 0;
    send_part(2, 11);
    send_part(1, W * H);
    drain;
    tick;
    chk("sync_err_cnt", se_cnt, 1);
    chk("frame_done_cnt", fd_cnt, 1);
    check_frame(1);
    // asynchronous reset during row 2
    send_part(0, 13);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_out_pixel", out_pixel, 0);
    chk("mid_rst_out_sof", out_sof, 0);
    chk("mid_rst_out_eol", out_eol, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    model_reset;
    tick;
    tick;
    rst_n = 1'b1;
    tick;
    cap_n = 0;
    send_part(0, W * H);
    drain;
    check_frame(0);
    // random frames, random input gaps, random downstream stalls
    rnd_mode = 1;
    repeat (4) begin
      for (int p = 0; p < W * H; p++) begin
        repeat ($urandom_range(0, 2) == 0 ? $urandom_range(1, 2) : 0) tick;
        send(8'($urandom), p == 0);
      end
    end
    drain;
    rnd_mode = 0;
    tick;
    tick;
    chk("final_queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
